// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: ALU opcode constants, writeback destination
// encodings and the writeback FSM state encoding.
package cpu_defs;

   // 5-bit ALU opcodes (same encoding as the ALU)
   localparam logic [4:0] OP_LOAD       = 5'b00000;
   localparam logic [4:0] OP_STORE      = 5'b00010;
   localparam logic [4:0] OP_ADD        = 5'b00011;
   localparam logic [4:0] OP_MUL        = 5'b01111;
   localparam logic [4:0] OP_DIV        = 5'b10000;
   localparam logic [4:0] OP_LAST_WRITE = 5'b10010;  // highest opcode that writes back

   // Destination selects driven with each bus word
   localparam logic [1:0] DEST_RZ  = 2'b00;
   localparam logic [1:0] DEST_LO  = 2'b01;
   localparam logic [1:0] DEST_HI  = 2'b10;
   localparam logic [1:0] DEST_MAR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_XFER_LO = 2'b01,
      ST_XFER_HI = 2'b10,
      ST_FINISH  = 2'b11
   } wb_state_e;

   // Opcodes above OP_LAST_WRITE produce no bus traffic
   function automatic logic op_writes(input logic [4:0] op);
      return (op <= OP_LAST_WRITE);
   endfunction

   // mul/div return a 64-bit result split over LO and HI
   function automatic logic op_two_word(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   // Destination of the first (or only) word
   function automatic logic [1:0] first_dest(input logic [4:0] op);
      if ((op == OP_LOAD) || (op == OP_STORE))
         return DEST_MAR;
      else if (op_two_word(op))
         return DEST_LO;
      else
         return DEST_RZ;
   endfunction

endpackage

// File: rtl/alu_writeback.sv
// ALU writeback stage: captures the 64-bit ALU result into Z on start and
// streams it onto the 32-bit bus as one or two valid/ready transfers,
// each tagged with its destination register.
//
// Handshake: a word moves on a rising edge where bus_valid=1 and
// bus_ready=1. While bus_valid is high, bus_data and dest_sel are held
// stable; bus_valid only falls after a transfer or a wait timeout.
module alu_writeback
   import cpu_defs::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [4:0]  opcode,
   input  logic [63:0] c,
   input  logic        bus_ready,
   output logic        bus_valid,
   output logic [31:0] bus_data,
   output logic [1:0]  dest_sel,
   output logic        busy,
   output logic        done,
   output logic        err
);

   // Counter wide enough to hold TIMEOUT; one bit when the timeout is disabled
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   wb_state_e     state_q, state_d;
   logic [63:0]   z_q;
   logic [4:0]    op_q;
   logic [1:0]    dest_q;
   logic [CW-1:0] wait_cnt;
   logic          err_q;
   logic          in_xfer;
   logic          timeout_hit;

   assign in_xfer = (state_q == ST_XFER_LO) || (state_q == ST_XFER_HI);
   // The stalled cycle that brings the counter to TIMEOUT aborts the word
   assign timeout_hit = (TIMEOUT != 0) && in_xfer && !bus_ready && (wait_cnt == LIMIT);

   // State register
   always_ff @(posedge clk or posedge clr) begin
      if (clr) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = op_writes(opcode) ? ST_XFER_LO : ST_FINISH;
         end
         ST_XFER_LO: begin
            if (bus_ready)        state_d = op_two_word(op_q) ? ST_XFER_HI : ST_FINISH;
            else if (timeout_hit) state_d = ST_IDLE;
         end
         ST_XFER_HI: begin
            if (bus_ready)        state_d = ST_FINISH;
            else if (timeout_hit) state_d = ST_IDLE;
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Z/opcode capture, destination tag, wait counter and error pulse
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         z_q      <= '0;
         op_q     <= '0;
         dest_q   <= DEST_RZ;
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         err_q <= timeout_hit;
         if ((state_q == ST_IDLE) && start) begin
            z_q      <= c;
            op_q     <= opcode;
            dest_q   <= first_dest(opcode);
            wait_cnt <= '0;
         end else if ((state_q == ST_XFER_LO) && bus_ready && op_two_word(op_q)) begin
            dest_q   <= DEST_HI;
            wait_cnt <= '0;
         end else if (in_xfer && !bus_ready && (TIMEOUT != 0)) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

   // Outputs decoded from registered state only
   always_comb begin
      bus_valid = in_xfer;
      bus_data  = '0;
      if (state_q == ST_XFER_LO)      bus_data = z_q[31:0];
      else if (state_q == ST_XFER_HI) bus_data = z_q[63:32];
      dest_sel  = in_xfer ? dest_q : 2'b00;
      busy      = (state_q != ST_IDLE);
      done      = (state_q == ST_FINISH);
      err       = err_q;
   end

endmodule

// File: tb/tb_alu_writeback.sv
// Testbench for alu_writeback: directed timing cases followed by random
// opcode/data/backpressure traffic checked against a transfer-list model.
module tb_alu_writeback;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [4:0]  opcode;
  logic [63:0] c;
  logic        bus_ready;
  logic        bus_valid;
  logic [31:0] bus_data;
  logic [1:0]  dest_sel;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;
  int err_seen  = 0;
  int exp_done  = 0;
  int exp_err   = 0;
  logic [33:0] exp_q[$];   // {dest_sel, bus_data} in transfer order

  logic        rand_en = 1'b0;
  int          stall_run = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [33:0] prev_word = '0;

  alu_writeback #(.TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr), .start(start), .opcode(opcode), .c(c),
    .bus_ready(bus_ready), .bus_valid(bus_valid), .bus_data(bus_data),
    .dest_sel(dest_sel), .busy(busy), .done(done), .err(err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Words the writeback must put on the bus for one instruction.
  task automatic model_push(input logic [4:0] op, input logic [63:0] data);
    logic [1:0] d;
    if (op > 5'd18) return;                 // no-write opcodes
    if (op == 5'd0 || op == 5'd2)       d = 2'b11;
    else if (op == 5'd15 || op == 5'd16) d = 2'b01;
    else                                d = 2'b00;
    exp_q.push_back({d, data[31:0]});
    if (op == 5'd15 || op == 5'd16) exp_q.push_back({2'b10, data[63:32]});
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (clr) begin
      prev_valid = 1'b0;
    end else begin
      if (done) done_seen++;
      if (err)  err_seen++;
      if (!bus_valid) check("idle_data", {32'd0, bus_data}, 64'd0);
      if (prev_valid && !prev_ready && bus_valid)
        check("hold", {30'd0, dest_sel, bus_data}, {30'd0, prev_word});
      if (bus_valid && bus_ready) begin
        if (exp_q.size() == 0) check("xfer_unexpected", {30'd0, dest_sel, bus_data}, 64'd0 - 1);
        else check("xfer", {30'd0, dest_sel, bus_data}, {30'd0, exp_q.pop_front()});
      end
      prev_valid = bus_valid;
      prev_ready = bus_ready;
      prev_word  = {dest_sel, bus_data};
    end
  end

  // Random backpressure: never more than TO-1 stalled cycles in a row
  always @(posedge clk) begin
    if (rand_en) begin
      #1;
      if (stall_run >= TO - 1) bus_ready = 1'b1;
      else bus_ready = ($urandom_range(0, 2) != 0);
      stall_run = bus_ready ? 0 : stall_run + 1;
    end
  end

  // ---------------- driver tasks ----------------
  // Pulses start for one sampling edge; returns 1ns after that edge (edge k).
  task automatic issue(input logic [4:0] op, input logic [63:0] data, input bit completes);
    @(negedge clk);
    if (completes) begin
      model_push(op, data);
      exp_done++;
    end
    start = 1'b1; opcode = op; c = data;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 50);
    if (busy) check("wait_idle_bound", 64'd1, 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, {63'd0, bus_valid}, 64'd0);
    check({tag, "_data"},  {32'd0, bus_data},  64'd0);
    check({tag, "_dest"},  {62'd0, dest_sel},  64'd0);
    check({tag, "_busy"},  {63'd0, busy},      64'd0);
    check({tag, "_done"},  {63'd0, done},      64'd0);
    check({tag, "_err"},   {63'd0, err},       64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0, e0;
    clr = 1'b1; start = 1'b0; opcode = '0; c = '0; bus_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    clr = 1'b0;

    // Reset mid-transfer
    d0 = done_seen; e0 = err_seen;
    bus_ready = 1'b0;
    issue(5'd3, 64'h7, 1'b0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    #1 check_outputs_zero("midreset");
    @(negedge clk) clr = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_busy", {63'd0, busy}, 64'd0);
    check("midreset_no_done", done_seen, d0);
    check("midreset_no_err", err_seen, e0);

    // Single word add
    bus_ready = 1'b1;
    issue(5'd3, 64'h7, 1'b1);
    @(negedge clk);                         // cycle k
    check("add_busy_k", {63'd0, busy}, 64'd1);
    check("add_valid_k", {63'd0, bus_valid}, 64'd1);
    check("add_data_k", {32'd0, bus_data}, 64'h7);
    check("add_dest_k", {62'd0, dest_sel}, 64'd0);
    check("add_done_k", {63'd0, done}, 64'd0);
    @(negedge clk);                         // cycle k+1
    check("add_done_k1", {63'd0, done}, 64'd1);
    check("add_valid_k1", {63'd0, bus_valid}, 64'd0);
    @(negedge clk);                         // cycle k+2
    check("add_done_k2", {63'd0, done}, 64'd0);
    check("add_busy_k2", {63'd0, busy}, 64'd0);

    // mul: LO then HI
    issue(5'd15, 64'h0000_0001_8000_0000, 1'b1);
    @(negedge clk);
    check("mul_lo_data", {32'd0, bus_data}, 64'h8000_0000);
    check("mul_lo_dest", {62'd0, dest_sel}, 64'd1);
    @(negedge clk);
    check("mul_hi_data", {32'd0, bus_data}, 64'h1);
    check("mul_hi_dest", {62'd0, dest_sel}, 64'd2);
    check("mul_hi_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    check("mul_done", {63'd0, done}, 64'd1);
    wait_idle();

    // Store with 3 cycles of backpressure
    bus_ready = 1'b0;
    d0 = done_seen;
    issue(5'd2, 64'h0000_0000_0000_0090, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("st_stall_data", {32'd0, bus_data}, 64'h90);
      check("st_stall_dest", {62'd0, dest_sel}, 64'd3);
      @(posedge clk);
    end
    #1 bus_ready = 1'b1;
    @(negedge clk);
    check("st_last_valid", {63'd0, bus_valid}, 64'd1);
    @(negedge clk);
    check("st_done", {63'd0, done}, 64'd1);
    wait_idle();
    check("st_done_count", done_seen - d0, 1);

    // Timeout on div, with an ignored start while busy
    bus_ready = 1'b0;
    d0 = done_seen;
    exp_err++;
    issue(5'd16, 64'h1111_2222_3333_4444, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; opcode = 5'd3; c = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);                         // cycle k+2
    check("to_data_k2", {32'd0, bus_data}, 64'h3333_4444);
    @(negedge clk);                         // cycle k+3
    check("to_valid_k3", {63'd0, bus_valid}, 64'd1);
    check("to_err_k3", {63'd0, err}, 64'd0);
    @(negedge clk);                         // cycle k+4
    check("to_err_k4", {63'd0, err}, 64'd1);
    check("to_valid_k4", {63'd0, bus_valid}, 64'd0);
    check("to_busy_k4", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("to_err_k5", {63'd0, err}, 64'd0);
    check("to_no_done", done_seen, d0);

    // Illegal opcode: done in cycle k, no bus traffic
    bus_ready = 1'b1;
    issue(5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    @(negedge clk);
    check("ill_done_k", {63'd0, done}, 64'd1);
    check("ill_valid_k", {63'd0, bus_valid}, 64'd0);
    @(negedge clk);
    check("ill_done_k1", {63'd0, done}, 64'd0);
    check("ill_busy_k1", {63'd0, busy}, 64'd0);

    // Random traffic
    rand_en = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic [4:0]  op;
      logic [63:0] data;
      wait_idle();
      op   = 5'($urandom_range(0, 31));
      data = {$urandom, $urandom};
      issue(op, data, 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        if (busy) begin
          start = 1'b1; opcode = 5'($urandom_range(0, 31)); c = {$urandom, $urandom};
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
    end
    wait_idle();
    rand_en = 1'b0;
    repeat (3) @(negedge clk);

    check("final_queue_empty", exp_q.size(), 0);
    check("final_done_count", done_seen, exp_done);
    check("final_err_count", err_seen, exp_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
